// File: rtl/oh_rr_arb2_pkg.sv
// Shared types and constants for the two-port packet round-robin arbiter.
package oh_rr_arb2_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLock0 = 2'd1,
    StLock1 = 2'd2
  } state_e;

  localparam int unsigned Port0 = 0;
  localparam int unsigned Port1 = 1;

endpackage

// File: rtl/oh_rr_arb2_sel.sv
// AND-OR select of payload and last flag; gnt is one-hot or zero.
module oh_rr_arb2_sel
  import oh_rr_arb2_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic [1:0]    gnt,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic [DW-1:0] sel_data,
  output logic          sel_last
);

  assign sel_data = (in0_data & {DW{gnt[Port0]}}) | (in1_data & {DW{gnt[Port1]}});
  assign sel_last = (in0_last & gnt[Port0]) | (in1_last & gnt[Port1]);

endmodule

// File: rtl/oh_rr_arb2.sv
// Two-port packet arbiter with per-packet lock and registered output beat.
// Define OH_RR_ARB2_FIXED_PRIO_EN to give port 0 fixed priority instead of round robin.
module oh_rr_arb2
  import oh_rr_arb2_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in0_valid,
  input  logic          in0_last,
  input  logic [DW-1:0] in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic          in1_last,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    gnt
);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          ld;
  logic          accept;
  logic          winner;
  logic [DW-1:0] sel_data;
  logic          sel_last;

  assign ld        = ~out_valid | out_ready;
  assign in0_ready = ld & gnt[Port0];
  assign in1_ready = ld & gnt[Port1];
  assign accept    = ld & ((gnt[Port0] & in0_valid) | (gnt[Port1] & in1_valid));
  assign winner    = gnt[Port1];

  // Grant depends only on state and valids so readies never loop back into valids.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
`ifdef OH_RR_ARB2_FIXED_PRIO_EN
          if (in0_valid)      gnt = 2'b01;
          else if (in1_valid) gnt = 2'b10;
`else
          if (in0_valid && in1_valid) gnt = ptr_q ? 2'b10 : 2'b01;
          else if (in0_valid)         gnt = 2'b01;
          else if (in1_valid)         gnt = 2'b10;
`endif
        end
        StLock0: gnt = 2'b01;
        StLock1: gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (sel_last) begin
        state_d = StIdle;
`ifndef OH_RR_ARB2_FIXED_PRIO_EN
        ptr_d   = ~winner;
`endif
      end else begin
        state_d = winner ? StLock1 : StLock0;
      end
    end
  end

  oh_rr_arb2_sel #(
    .DW (DW)
  ) u_sel (
    .gnt      (gnt),
    .in0_data (in0_data),
    .in0_last (in0_last),
    .in1_data (in1_data),
    .in1_last (in1_last),
    .sel_data (sel_data),
    .sel_last (sel_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_oh_rr_arb2.sv
// Scoreboard bench for oh_rr_arb2 (DW=8); source queues feed the ports, expected beats queue up.
module tb_oh_rr_arb2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in0_valid, in0_last, in0_ready;
  logic [7:0] in0_data;
  logic       in1_valid, in1_last, in1_ready;
  logic [7:0] in1_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic [1:0] gnt;

  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] exp_q[$];
  int         stamp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       hs0, hs1;
  logic [8:0] e;

  oh_rr_arb2 #(
    .DW (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_valid (in0_valid),
    .in0_last  (in0_last),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_last  (in1_last),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .gnt       (gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic drive();
    in0_valid = (src0.size() != 0);
    {in0_last, in0_data} = in0_valid ? src0[0] : 9'h000;
    in1_valid = (src1.size() != 0);
    {in1_last, in1_data} = in1_valid ? src1[0] : 9'h000;
  endtask

  // One clock: score the output beat, then retire handshaken source beats.
  task automatic tick();
    @(negedge clk);
    hs0 = in0_valid & in0_ready;
    hs1 = in1_valid & in1_ready;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: got %h, expected no beat", {out_last, out_data});
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          bad++;
          $display("FAIL out_beat: got %h, expected %h", {out_last, out_data}, e);
        end
      end
      stamp_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (hs0 === 1'b1) void'(src0.pop_front());
    if (hs1 === 1'b1) void'(src1.pop_front());
    drive();
  endtask

  task automatic drain(input int max);
    for (int n = 0; n < max && exp_q.size() != 0; n++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src0.delete();
    src1.delete();
    exp_q.delete();
    drive();
    tick();
    tick();
    reset = 1'b0;
    stamp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    src0.push_back({1'b1, 8'h01});
    src1.push_back({1'b1, 8'h02});
    drive();
    #1;
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt_early: got %b, expected 00", gnt); end
    tick();
    tick();
    total++;
    if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt: got %b, expected 00", gnt); end
    total++;
    if ({in0_ready, in1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready: got %b, expected 00", {in0_ready, in1_ready});
    end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    total++;
    if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
    src0.delete();
    src1.delete();
    reset = 1'b0;
    drive();
  endtask

  task automatic test_round_robin();
    logic [7:0] a, b;
    int span;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'hA0 + 8'(i);
      b = 8'hB0 + 8'(i);
      src0.push_back({1'b1, a});
      src1.push_back({1'b1, b});
      exp_q.push_back({1'b1, a});
      exp_q.push_back({1'b1, b});
    end
    drive();
    drain(40);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rr_drain: %0d beats left, expected 0", exp_q.size()); end
    span = (stamp_q.size() == 12) ? stamp_q[11] - stamp_q[0] : -1;
    total++;
    if (span !== 11) begin bad++; $display("FAIL rr_rate: 12 beats over %0d cycles, expected 11", span); end
  endtask

  task automatic test_fixed_prio();
    logic [7:0] a;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'hA0 + 8'(i);
      src0.push_back({1'b1, a});
      exp_q.push_back({1'b1, a});
    end
    src1.push_back({1'b1, 8'hB0});
    src1.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b1, 8'hB1});
    drive();
    #1;
    total++;
    if (in1_ready !== 1'b0) begin bad++; $display("FAIL fixed_starve: in1_ready=%b, expected 0", in1_ready); end
    drain(40);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL fixed_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_lock();
    do_reset();
    out_ready = 1'b1;
    src1.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b1, 8'h13});
    exp_q.push_back({1'b1, 8'hA0});
    drive();
    tick();
    src0.push_back({1'b1, 8'hA0});
    drive();
    #1;
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL lock_gnt: got %b, expected 10", gnt); end
    total++;
    if (in0_ready !== 1'b0) begin bad++; $display("FAIL lock_ready0: got %b, expected 0", in0_ready); end
    tick();
    tick();
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL bubble_gnt: got %b, expected 10", gnt); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_out_valid: got %b, expected 0", out_valid); end
    src1.push_back({1'b0, 8'h12});
    src1.push_back({1'b1, 8'h13});
    drive();
    drain(20);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL lock_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    src0.push_back({1'b1, 8'h5A});
    src1.push_back({1'b1, 8'h6B});
    exp_q.push_back({1'b1, 8'h5A});
    exp_q.push_back({1'b1, 8'h6B});
    drive();
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
        bad++; $display("FAIL bp_hold: got v=%b d=%h, expected v=1 d=5a", out_valid, out_data);
      end
      total++;
      if ({in0_ready, in1_ready} !== 2'b00) begin
        bad++; $display("FAIL bp_ready: got %b, expected 00", {in0_ready, in1_ready});
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h6B) begin
      bad++; $display("FAIL bp_release: got v=%b d=%h, expected v=1 d=6b", out_valid, out_data);
    end
    drain(10);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b1;
    src0.push_back({1'b1, 8'hB0});
    src0.push_back({1'b0, 8'hC1});
    src0.push_back({1'b0, 8'hC2});
    src0.push_back({1'b1, 8'hC3});
    exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hC1});
    drive();
    tick();
    tick();
    reset = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b, expected 0", out_valid); end
    src0.delete();
    src1.delete();
    exp_q.delete();
    reset = 1'b0;
    src1.push_back({1'b1, 8'hF0});
    drive();
    #1;
    total++;
    if (gnt !== 2'b10) begin bad++; $display("FAIL mid_idle: gnt=%b, expected 10", gnt); end
    src0.push_back({1'b1, 8'hE0});
    drive();
    #1;
    total++;
    if (gnt !== 2'b01) begin bad++; $display("FAIL mid_ptr: gnt=%b, expected 01", gnt); end
    exp_q.push_back({1'b1, 8'hE0});
    exp_q.push_back({1'b1, 8'hF0});
    drain(10);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL mid_drain: %0d beats left, expected 0", exp_q.size()); end
  endtask

  initial begin
    out_ready = 1'b1;
    test_reset();
`ifdef OH_RR_ARB2_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
`endif
    test_lock();
    test_backpressure();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oh_rr_arb2.md
OH_RR_ARB2 -- requirements
Module: oh_rr_arb2

Interface
REQ-001 SHALL have parameter: DW, 1, data width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in0_valid, in0_last  input  1 each  requester 0 beat valid, end of packet.
REQ-005 SHALL have port: in0_data  input  DW  requester 0 payload.
REQ-006 SHALL have port: in0_ready  output  1  requester 0 beat accepted this cycle.
REQ-007 SHALL have ports: in1_valid, in1_last, in1_data, in1_ready, same as requester 0 but for requester 1.
REQ-008 SHALL have ports: out_valid, out_last  output  1 each  registered output beat valid, end of packet.
REQ-009 SHALL have port: out_data  output  DW  registered payload.
REQ-010 SHALL have port: out_ready  input  1  downstream accepts out beat.
REQ-011 SHALL have port: gnt  output  2  one-hot or zero select driving shared AND-OR datapath.

Function
REQ-012 SHALL define ld = ~out_valid | out_ready; inX_ready = ld & gnt[X].
REQ-013 SHALL implement FSM states IDLE, LOCK0, LOCK1.
REQ-014 SHALL, in IDLE: both valid -> gnt to port ptr; one valid -> that port; none -> gnt=0.
REQ-015 SHALL, in LOCKx: gnt[x]=1 regardless of either valid; other port ready=0.
REQ-016 SHALL on accepted beat with last=0 from IDLE move to LOCK(winner); last=1 stays IDLE.
REQ-017 SHALL on accepted beat with last=1 in LOCKx return to IDLE.
REQ-018 SHALL update ptr <= ~winner on every accepted last=1 beat (round robin).
REQ-019 SHALL load out_data = (in0_data & {DW{gnt[0]}}) | (in1_data & {DW{gnt[1]}}), and out_last likewise, when a beat is accepted.
REQ-020 SHALL set out_valid<=1 on accept; out_valid<=0 when out_ready and no accept.
REQ-021 SHALL give 1-cycle latency from accept to out_valid and sustain 1 beat/cycle when out_ready=1.
REQ-022 SHALL hold out_valid/out_data/out_last stable while out_valid & ~out_ready.
REQ-023 SHALL keep gnt combinationally dependent on valids only; readies never feed valids.
REQ-024 SHALL, in LOCKx with inX_valid=0, hold lock and accept nothing (bubble).

Reset
REQ-025 SHALL on reset=1 at a clock edge set out_valid=0, out_last=0, out_data=0, state=IDLE, ptr=0.
REQ-026 SHALL force gnt=0 and in0_ready=in1_ready=0 while reset=1.
REQ-027 SHALL, on reset mid-packet or with out beat pending, discard lock and pending beat without completion.

Configuration
REQ-028 SHALL, with OH_RR_ARB2_FIXED_PRIO_EN defined, grant port 0 in IDLE whenever in0_valid=1 and never update ptr.
REQ-029 SHALL, without OH_RR_ARB2_FIXED_PRIO_EN, use round robin per REQ-014/REQ-018.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/LOCK0/LOCK1) and port-index constants in package oh_rr_arb2_pkg.
REQ-031 SHALL implement the AND-OR data/last select in one sub-module oh_rr_arb2_sel (parameter DW) and keep all state in oh_rr_arb2.

Verification (DW=8)
REQ-032 SHALL check reset: assert reset for 2 cycles with both valid -> gnt=0, readies=0, out_valid=0, out_data=0x00.
REQ-033 SHALL check round robin: both valid single-beat (last=1) continuously, out_ready=1 -> outputs alternate port0,port1,port0,... at one beat/cycle.
REQ-034 SHALL check lock: port1 sends 3-beat packet 0x11,0x12,0x13(last), port0 valid throughout -> all port1 beats emitted before port0 0xA0.
REQ-035 SHALL check backpressure: out_ready=0 for 4 cycles with out_data=0x5A -> out_data holds 0x5A, both readies 0; release -> next beat 1 cycle later.
REQ-036 SHALL check reset mid-packet: reset after first of 3 port0 beats -> state IDLE, out_valid=0, next arbitration from ptr=0.
REQ-037 SHALL check macro build: OH_RR_ARB2_FIXED_PRIO_EN defined, both valid single-beat -> port0 wins every cycle, port1 starved.
